// File: rtl/bmp_scan_pkg.sv
// Shared types and default geometry for the bitmap scan sequencer.
// Pulled into the top and the watchdog with a wildcard import.
package bmp_scan_pkg;

   localparam int DEF_NCOLS  = 24;
   localparam int DEF_NROWS  = 64;
   localparam int DEF_TO_CYC = 15;

   typedef enum logic [3:0] {
      ST_IDLE     = 4'd0,
      ST_LOAD     = 4'd1,
      ST_SETTLE   = 4'd2,
      ST_REQ      = 4'd3,
      ST_WAIT_RDY = 4'd4,
      ST_START    = 4'd5,
      ST_WAIT_ALU = 4'd6,
      ST_DONE     = 4'd7,
      ST_ERR      = 4'd8
   } state_t;

   typedef enum logic [1:0] {
      MODE_COL = 2'b00,
      MODE_TOP = 2'b01,
      MODE_BOT = 2'b10,
      MODE_RSV = 2'b11
   } mode_t;

   typedef enum logic [1:0] {
      ERR_NONE    = 2'b00,
      ERR_MODE    = 2'b01,
      ERR_TIMEOUT = 2'b10,
      ERR_ABORT   = 2'b11
   } err_t;

endpackage

// File: rtl/bmp_scan_wdog.sv
// Ready-wait watchdog: 4-bit counter cleared on request, counting while enabled.
// o_expire flags the last permitted waiting cycle so the FSM can leave on the next edge.
module bmp_scan_wdog
   import bmp_scan_pkg::*;
#(
   parameter int TO_CYC = DEF_TO_CYC
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_clr,
   input  logic i_en,
   output logic o_expire
);

   logic [3:0] r_cnt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cnt <= 4'd0;
      end else if (i_clr) begin
         r_cnt <= 4'd0;
      end else if (i_en && (r_cnt != 4'hF)) begin
         r_cnt <= r_cnt + 4'd1;
      end
   end

   assign o_expire = i_en && (r_cnt >= 4'(TO_CYC - 1));

endmodule

// File: rtl/bmp_scan_sequencer.sv
// Runs one scan job: load the bitmap register, then per slice request it, wait for ready,
// start the compare ALU and wait for completion. All strobes are decoded from the state.
module bmp_scan_sequencer
   import bmp_scan_pkg::*;
#(
   parameter int NCOLS  = DEF_NCOLS,
   parameter int NROWS  = DEF_NROWS,
   parameter int TO_CYC = DEF_TO_CYC
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       job_valid,
   output logic       job_ready,
   input  logic [1:0] job_mode,
   input  logic       abort,
   output logic       bmp_wren,
   output logic       bmp_nextcol,
   output logic       bmp_nextrowtop,
   output logic       bmp_nextrowbot,
   input  logic       bmp_colready,
   input  logic       bmp_rowtopready,
   input  logic       bmp_rowbotready,
   output logic       alu_start,
   output logic [5:0] alu_idx,
   output logic       alu_last,
   input  logic       alu_done,
   output logic       busy,
   output logic       job_done,
   output logic       job_err,
   output logic [1:0] err_code,
   output logic [3:0] o_dbg_state
);

   // Handshake: a job is taken on any rising edge where job_valid && job_ready; job_ready
   // is high only in IDLE, so requests made while busy are dropped, never queued.

   localparam logic [5:0] COL_LAST = 6'(NCOLS - 1);
   localparam logic [5:0] ROW_LAST = 6'(NROWS - 1);

   state_t     r_state;
   state_t     w_next;
   mode_t      r_mode;
   err_t       r_err;
   err_t       w_err_next;
   logic [5:0] r_cnt;
   logic       w_cnt_inc;
   logic       w_accept;
   logic       w_rdy;
   logic       w_last;
   logic       w_abortable;
   logic       w_expire;

   assign w_accept    = (r_state == ST_IDLE) && job_valid;
   assign w_last      = (r_cnt == ((r_mode == MODE_COL) ? COL_LAST : ROW_LAST));
   assign w_abortable = (r_state != ST_IDLE) && (r_state != ST_DONE) && (r_state != ST_ERR);

   always_comb begin
      w_rdy = 1'b0;
      case (r_mode)
         MODE_COL: w_rdy = bmp_colready;
         MODE_TOP: w_rdy = bmp_rowtopready;
         MODE_BOT: w_rdy = bmp_rowbotready;
         default:  w_rdy = 1'b0;
      endcase
   end

   bmp_scan_wdog #(.TO_CYC(TO_CYC)) u_wdog (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_clr    (r_state == ST_REQ),
      .i_en     (r_state == ST_WAIT_RDY),
      .o_expire (w_expire)
   );

   always_comb begin
      w_next         = r_state;
      w_err_next     = r_err;
      w_cnt_inc      = 1'b0;
      job_ready      = (r_state == ST_IDLE);
      busy           = (r_state != ST_IDLE);
      bmp_wren       = 1'b0;
      bmp_nextcol    = 1'b0;
      bmp_nextrowtop = 1'b0;
      bmp_nextrowbot = 1'b0;
      alu_start      = 1'b0;
      alu_last       = 1'b0;
      job_done       = 1'b0;
      job_err        = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (job_valid) begin
               if (mode_t'(job_mode) == MODE_RSV) begin
                  w_next     = ST_ERR;
                  w_err_next = ERR_MODE;
               end else begin
                  w_next     = ST_LOAD;
                  w_err_next = ERR_NONE;
               end
            end
         end
         ST_LOAD: begin
            bmp_wren = 1'b1;
            w_next   = ST_SETTLE;
         end
         ST_SETTLE: w_next = ST_REQ;
         ST_REQ: begin
            bmp_nextcol    = (r_mode == MODE_COL);
            bmp_nextrowtop = (r_mode == MODE_TOP);
            bmp_nextrowbot = (r_mode == MODE_BOT);
            w_next         = ST_WAIT_RDY;
         end
         ST_WAIT_RDY: begin
            // A ready on the final permitted cycle still wins over the timeout.
            if (w_rdy) begin
               w_next = ST_START;
            end else if (w_expire) begin
               w_next     = ST_ERR;
               w_err_next = ERR_TIMEOUT;
            end
         end
         ST_START: begin
            alu_start = 1'b1;
            alu_last  = w_last;
            w_next    = ST_WAIT_ALU;
         end
         ST_WAIT_ALU: begin
            if (alu_done) begin
               if (w_last) begin
                  w_next = ST_DONE;
               end else begin
                  w_cnt_inc = 1'b1;
                  w_next    = ST_REQ;
               end
            end
         end
         ST_DONE: begin
            job_done = 1'b1;
            w_next   = ST_IDLE;
         end
         ST_ERR: begin
            job_err = 1'b1;
            w_next  = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
      if (abort && w_abortable) begin
         w_next     = ST_ERR;
         w_err_next = ERR_ABORT;
         w_cnt_inc  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_mode  <= MODE_COL;
         r_err   <= ERR_NONE;
         r_cnt   <= 6'd0;
      end else begin
         r_state <= w_next;
         r_err   <= w_err_next;
         if (w_accept) begin
            r_mode <= mode_t'(job_mode);
            r_cnt  <= 6'd0;
         end else if (w_cnt_inc) begin
            r_cnt <= r_cnt + 6'd1;
         end
      end
   end

   assign alu_idx     = r_cnt;
   assign err_code    = r_err;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_bmp_scan_sequencer.sv
// Bench for bmp_scan_sequencer: an open-loop job timeline derived from the cycle rules
// predicts every output in every cycle; event counters pin the totals per scenario.
module tb_bmp_scan_sequencer;

   localparam int W = 19;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       job_valid;
   logic       job_ready;
   logic [1:0] job_mode;
   logic       abort;
   logic       bmp_wren, bmp_nextcol, bmp_nextrowtop, bmp_nextrowbot;
   logic       bmp_colready, bmp_rowtopready, bmp_rowbotready;
   logic       alu_start;
   logic [5:0] alu_idx;
   logic       alu_last;
   logic       alu_done;
   logic       busy, job_done, job_err;
   logic [1:0] err_code;
   logic [3:0] dbg_state;

   always #5 clk = ~clk;

   bmp_scan_sequencer dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .job_valid       (job_valid),
      .job_ready       (job_ready),
      .job_mode        (job_mode),
      .abort           (abort),
      .bmp_wren        (bmp_wren),
      .bmp_nextcol     (bmp_nextcol),
      .bmp_nextrowtop  (bmp_nextrowtop),
      .bmp_nextrowbot  (bmp_nextrowbot),
      .bmp_colready    (bmp_colready),
      .bmp_rowtopready (bmp_rowtopready),
      .bmp_rowbotready (bmp_rowbotready),
      .alu_start       (alu_start),
      .alu_idx         (alu_idx),
      .alu_last        (alu_last),
      .alu_done        (alu_done),
      .busy            (busy),
      .job_done        (job_done),
      .job_err         (job_err),
      .err_code        (err_code),
      .o_dbg_state     (dbg_state)
   );

   // Expected word: busy, job_ready, wren, {nextcol,nexttop,nextbot}, start, last,
   // idx[5:0], done, err, code[1:0], idx-check flag.
   logic [W-1:0] exp_q[$];

   typedef struct {
      string nm;
      int    act;
      int    req;
   } pin_t;
   pin_t pin_q[$];

   int total = 0;
   int bad   = 0;

   int c_wren = 0, c_col = 0, c_top = 0, c_bot = 0, c_start = 0, c_last = 0;
   int c_done = 0, c_err = 0, last_idx = -1;
   int s_wren, s_col, s_top, s_bot, s_start, s_last, s_done, s_err;

   logic [1:0] cur_code;

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      logic [W-1:0] e, a, m;
      pin_t p;
      c_wren  += int'(bmp_wren);
      c_col   += int'(bmp_nextcol);
      c_top   += int'(bmp_nextrowtop);
      c_bot   += int'(bmp_nextrowbot);
      c_start += int'(alu_start);
      c_done  += int'(job_done);
      c_err   += int'(job_err);
      if (alu_start && alu_last) begin
         c_last  += 1;
         last_idx = int'(alu_idx);
      end
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         a = {busy, job_ready, bmp_wren, bmp_nextcol, bmp_nextrowtop, bmp_nextrowbot,
              alu_start, alu_last, alu_idx, job_done, job_err, err_code, 1'b0};
         m = e[0] ? 19'h7FFFE : 19'h7F81E;
         total += 1;
         if (((a ^ e) & m) != '0) begin
            bad += 1;
            $display("FAIL outputs t=%0t act=%h req=%h mask=%h", $time, a, e, m);
         end
      end
      while (pin_q.size() > 0) begin
         p = pin_q.pop_front();
         total += 1;
         if (p.act != p.req) begin
            bad += 1;
            $display("FAIL %s act=%0d req=%0d", p.nm, p.act, p.req);
         end
      end
   end

   // ---------------- driver helpers ----------------
   function automatic logic [W-1:0] mk(input logic b, input logic jr, input logic wr,
                                       input logic [2:0] nx, input logic st, input logic ls,
                                       input logic [5:0] ix, input logic dn, input logic er,
                                       input logic [1:0] cd);
      return {b, jr, wr, nx, st, ls, ix, dn, er, cd, st};
   endfunction

   function automatic logic [W-1:0] e_idle(input logic [1:0] cd);
      return mk(1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, cd);
   endfunction

   function automatic logic [W-1:0] e_busy(input logic [1:0] cd);
      return mk(1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, cd);
   endfunction

   task automatic tick(input logic [W-1:0] e);
      exp_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic pin(input string nm, input int act, input int req);
      pin_t p;
      p.nm  = nm;
      p.act = act;
      p.req = req;
      pin_q.push_back(p);
   endtask

   // Random traffic on everything the current state must ignore; sel marks the
   // ready that belongs to the job and is therefore held low here.
   task automatic noise(input logic [2:0] sel);
      logic [2:0] r;
      r = 3'($urandom);
      r = r & ~sel;
      {bmp_colready, bmp_rowtopready, bmp_rowbotready} = r;
      job_valid = 1'($urandom_range(0, 1));
      job_mode  = 2'($urandom);
      alu_done  = 1'($urandom_range(0, 1));
   endtask

   task automatic set_match(input logic [2:0] sel, input logic v);
      if (sel[2]) bmp_colready    = v;
      if (sel[1]) bmp_rowtopready = v;
      if (sel[0]) bmp_rowbotready = v;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         noise(3'b000);
         job_valid = 1'b0;
         alu_done  = 1'b0;
         abort     = 1'($urandom_range(0, 1));
         tick(e_idle(cur_code));
      end
      abort = 1'b0;
   endtask

   task automatic snapshot();
      s_wren = c_wren; s_col = c_col; s_top = c_top; s_bot = c_bot;
      s_start = c_start; s_last = c_last; s_done = c_done; s_err = c_err;
   endtask

   // One job. fix_rd/fix_ad: fixed ready/done delays (0 = random). to_s: slice whose ready
   // never comes. ab_s: slice aborted together with alu_done. rst_s: slice reset in WAIT_ALU.
   // slow_s: slice whose ready arrives on the last permitted waiting cycle.
   task automatic run_job(input logic [1:0] mode, input int fix_rd, input int fix_ad,
                          input int to_s, input int ab_s, input int rst_s, input int slow_s);
      int n, rd, ad;
      logic [2:0] sel;
      n   = (mode == 2'b00) ? 24 : 64;
      sel = (mode == 2'b00) ? 3'b100 : (mode == 2'b01) ? 3'b010 :
            (mode == 2'b10) ? 3'b001 : 3'b000;
      noise(3'b000);
      alu_done  = 1'b0;
      job_valid = 1'b1;
      job_mode  = mode;
      abort     = 1'($urandom_range(0, 1));
      tick(e_idle(cur_code));
      abort = 1'b0;
      if (mode == 2'b11) begin
         noise(sel);
         abort    = 1'($urandom_range(0, 1));
         cur_code = 2'b01;
         tick(mk(1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 6'd0, 1'b0, 1'b1, cur_code));
         abort     = 1'b0;
         job_valid = 1'b0;
         return;
      end
      cur_code = 2'b00;
      noise(sel);
      tick(mk(1'b1, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, cur_code));
      noise(sel);
      tick(e_busy(cur_code));
      for (int s = 0; s < n; s++) begin
         noise(sel);
         tick(mk(1'b1, 1'b0, 1'b0, sel, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, cur_code));
         if (s == to_s) begin
            for (int k = 0; k < 15; k++) begin
               noise(sel);
               tick(e_busy(cur_code));
            end
            noise(sel);
            cur_code = 2'b10;
            tick(mk(1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 6'd0, 1'b0, 1'b1, cur_code));
            job_valid = 1'b0;
            return;
         end
         rd = (s == slow_s) ? 15 : (fix_rd != 0) ? fix_rd : int'($urandom_range(1, 4));
         for (int k = 1; k <= rd; k++) begin
            noise(sel);
            set_match(sel, k == rd);
            tick(e_busy(cur_code));
         end
         noise(sel);
         tick(mk(1'b1, 1'b0, 1'b0, 3'b000, 1'b1, s == n - 1, 6'(s), 1'b0, 1'b0, cur_code));
         ad = (fix_ad != 0) ? fix_ad : int'($urandom_range(1, 3));
         for (int k = 1; k <= ad; k++) begin
            noise(sel);
            alu_done = (k == ad);
            if (s == rst_s && k == ad) begin
               rst_n = 1'b0;
               tick(e_busy(cur_code));
               rst_n     = 1'b1;
               cur_code  = 2'b00;
               job_valid = 1'b0;
               alu_done  = 1'b0;
               return;
            end
            if (s == ab_s && k == ad) abort = 1'b1;
            tick(e_busy(cur_code));
            abort = 1'b0;
         end
         if (s == ab_s) begin
            noise(sel);
            cur_code = 2'b11;
            tick(mk(1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 6'd0, 1'b0, 1'b1, cur_code));
            job_valid = 1'b0;
            return;
         end
      end
      noise(sel);
      abort = 1'($urandom_range(0, 1));
      tick(mk(1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 6'd0, 1'b1, 1'b0, cur_code));
      abort     = 1'b0;
      job_valid = 1'b0;
   endtask

   // ---------------- clock/reset and scenarios ----------------
   initial begin
      rst_n     = 1'b0;
      job_valid = 1'b0;
      job_mode  = 2'b00;
      abort     = 1'b0;
      alu_done  = 1'b0;
      {bmp_colready, bmp_rowtopready, bmp_rowbotready} = 3'b000;
      cur_code  = 2'b00;
      @(posedge clk);
      #1;
      tick(e_idle(2'b00));
      rst_n = 1'b1;
      idle(2);

      // full column job, fixed latencies
      snapshot();
      run_job(2'b00, 1, 2, -1, -1, -1, -1);
      idle(1);
      pin("col_wren", c_wren - s_wren, 1);
      pin("col_nextcol", c_col - s_col, 24);
      pin("col_start", c_start - s_start, 24);
      pin("col_last_cnt", c_last - s_last, 1);
      pin("col_last_idx", last_idx, 23);
      pin("col_done", c_done - s_done, 1);

      // column job with one ready on the final waiting cycle before timeout
      snapshot();
      run_job(2'b00, 0, 0, -1, -1, -1, 3);
      idle(1);
      pin("slow_done", c_done - s_done, 1);
      pin("slow_err", c_err - s_err, 0);

      // top-row job with foreign readys toggling
      snapshot();
      run_job(2'b01, 0, 0, -1, -1, -1, -1);
      idle(1);
      pin("top_nexttop", c_top - s_top, 64);
      pin("top_nextbot", c_bot - s_bot, 0);
      pin("top_nextcol", c_col - s_col, 0);
      pin("top_last_idx", last_idx, 63);
      pin("top_done", c_done - s_done, 1);

      // reserved mode
      snapshot();
      run_job(2'b11, 0, 0, -1, -1, -1, -1);
      idle(2);
      pin("rsv_wren", c_wren - s_wren, 0);
      pin("rsv_err", c_err - s_err, 1);

      // ready withheld after the 5th nextcol
      snapshot();
      run_job(2'b00, 0, 0, 4, -1, -1, -1);
      idle(3);
      pin("to_nextcol", c_col - s_col, 5);
      pin("to_err", c_err - s_err, 1);
      pin("to_done", c_done - s_done, 0);

      // abort together with alu_done on idx 10
      snapshot();
      run_job(2'b00, 0, 0, -1, 10, -1, -1);
      idle(2);
      pin("ab_nextcol", c_col - s_col, 11);
      pin("ab_err", c_err - s_err, 1);
      pin("ab_done", c_done - s_done, 0);

      // reset in WAIT_ALU, then a clean bottom-row job
      snapshot();
      run_job(2'b10, 0, 0, -1, -1, 7, -1);
      idle(2);
      pin("rst_done", c_done - s_done, 0);
      pin("rst_err", c_err - s_err, 0);
      snapshot();
      run_job(2'b10, 0, 0, -1, -1, -1, -1);
      idle(1);
      pin("bot_nextbot", c_bot - s_bot, 64);
      pin("bot_done", c_done - s_done, 1);

      // random jobs
      for (int j = 0; j < 5; j++) begin
         run_job(2'($urandom), 0, 0, -1, -1, -1, int'($urandom_range(0, 23)));
         idle(int'($urandom_range(1, 3)));
      end

      @(negedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
